// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Control FSM for a multicycle RV32I-subset datapath with a
//               shared instruction/data memory and a single ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        instr,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUfunc,
    output logic [2:0]         ImmSrc,
    output logic               RegWrite,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR1    = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b100;
    localparam logic [2:0] c_ALU_XOR = 3'b110;

    state_t     r_state;
    logic       r_illegal;
    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_pcwrite;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_unused;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_unused = &{1'b0, instr[24:15], instr[11:7]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_opcode)
                        c_OP_LOAD, c_OP_STORE: r_state <= S_MEMADR;
                        c_OP_RTYPE:            r_state <= S_EXECR;
                        c_OP_ITYPE:            r_state <= S_EXECI;
                        c_OP_BRANCH:           r_state <= S_BRANCH;
                        c_OP_JAL:              r_state <= S_JAL;
                        c_OP_JALR:             r_state <= S_JALR1;
                        c_OP_LUI:              r_state <= S_LUI;
                        default: begin
                            r_state   <= S_TRAP;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:   r_state <= (w_opcode == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_JALR1:    r_state <= S_JALR2;
                S_JALR2:    r_state <= S_ALUWB;
                S_LUI:      r_state <= S_FETCH;
                S_TRAP:     r_state <= S_TRAP;
                default: begin
                    r_state   <= S_TRAP;
                    r_illegal <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_pcwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUfunc    = c_ALU_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                case ({w_f7, w_f3})
                    10'b0100000_000: ALUfunc = c_ALU_SUB;
                    10'b0000000_111: ALUfunc = c_ALU_AND;
                    10'b0000000_110: ALUfunc = c_ALU_OR;
                    10'b0000000_010: ALUfunc = c_ALU_SLT;
                    default:         ALUfunc = c_ALU_ADD;
                endcase
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                case (w_f3)
                    3'b100:  ALUfunc = c_ALU_XOR;
                    3'b110:  ALUfunc = c_ALU_OR;
                    3'b010:  ALUfunc = c_ALU_SLT;
                    default: ALUfunc = c_ALU_ADD;
                endcase
            end
            S_ALUWB: w_regwrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUfunc   = c_ALU_SUB;
                // Only beq/bne are supported; other f3 codes fall through untaken.
                w_pcwrite = ((w_f3 == 3'b000) & zero) | ((w_f3 == 3'b001) & ~zero);
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcwrite = 1'b1;
            end
            S_JALR1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_JALR2: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcwrite = 1'b1;
            end
            S_LUI: begin
                ResultSrc  = 2'b11;
                w_regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (w_opcode)
            c_OP_STORE:  ImmSrc = 3'b001;
            c_OP_JAL:    ImmSrc = 3'b010;
            c_OP_BRANCH: ImmSrc = 3'b011;
            c_OP_LUI:    ImmSrc = 3'b100;
            default:     ImmSrc = 3'b000;
        endcase
    end

    // Write enables are killed combinationally so a reset aborts a store at once.
    assign PCWrite  = rst_n & w_pcwrite;
    assign MemWrite = rst_n & w_memwrite;
    assign IRWrite  = rst_n & w_irwrite;
    assign RegWrite = rst_n & w_regwrite;
    assign illegal  = r_illegal;
    assign state    = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench; a path-level instruction model predicts
//               the state trace and every control output cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ALUfunc, ImmSrc;
    logic [3:0]  state;

    int n_vec = 0;
    int n_err = 0;
    int m_state = 0;
    int m_pos = 0;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUfunc(ALUfunc),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    wire [21:0] got = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                       ALUSrcA, ALUSrcB, ALUfunc, ImmSrc, RegWrite, illegal};

    // Each opcode class walks a fixed list of states; nibble i is step i.
    function automatic void path_of(input logic [31:0] ins, output int len, output logic [23:0] p);
        case (ins[6:0])
            7'b0000011: begin p = {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};  len = 5; end
            7'b0100011: begin p = {4'd0, 4'd0, 4'd5, 4'd2, 4'd1, 4'd0};  len = 4; end
            7'b0110011: begin p = {4'd0, 4'd0, 4'd8, 4'd6, 4'd1, 4'd0};  len = 4; end
            7'b0010011: begin p = {4'd0, 4'd0, 4'd8, 4'd7, 4'd1, 4'd0};  len = 4; end
            7'b1100011: begin p = {4'd0, 4'd0, 4'd0, 4'd9, 4'd1, 4'd0};  len = 3; end
            7'b1101111: begin p = {4'd0, 4'd0, 4'd8, 4'd10, 4'd1, 4'd0}; len = 4; end
            7'b1100111: begin p = {4'd0, 4'd8, 4'd12, 4'd11, 4'd1, 4'd0}; len = 5; end
            7'b0110111: begin p = {4'd0, 4'd0, 4'd0, 4'd13, 4'd1, 4'd0}; len = 3; end
            default:    begin p = {4'd0, 4'd0, 4'd0, 4'd15, 4'd1, 4'd0}; len = 3; end
        endcase
    endfunction

    function automatic logic [21:0] exp_out(input int st, input logic [31:0] ins,
                                            input logic z, input logic rdy, input logic rn);
        logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
        logic [1:0] rs = 0, sa = 0, sb = 0;
        logic [2:0] af = 3'b000, imm = 3'b000;
        logic [2:0] f3 = ins[14:12];
        logic [9:0] ff = {ins[31:25], ins[14:12]};
        case (ins[6:0])
            7'b0100011: imm = 3'b001;
            7'b1101111: imm = 3'b010;
            7'b1100011: imm = 3'b011;
            7'b0110111: imm = 3'b100;
            default:    imm = 3'b000;
        endcase
        case (st)
            0:  begin sa = 0; sb = 2; rs = 2; pcw = rdy; irw = rdy; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin
                    sa = 2; sb = 0;
                    if (ff == 10'h100) af = 3'b001;
                    else if (ff == 10'h007) af = 3'b010;
                    else if (ff == 10'h006) af = 3'b011;
                    else if (ff == 10'h002) af = 3'b100;
                end
            7:  begin
                    sa = 2; sb = 1;
                    if (f3 == 3'b100) af = 3'b110;
                    else if (f3 == 3'b110) af = 3'b011;
                    else if (f3 == 3'b010) af = 3'b100;
                end
            8:  rw = 1;
            9:  begin sa = 2; af = 3'b001; pcw = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z); end
            10: begin sa = 1; sb = 2; pcw = 1; end
            11: begin sa = 2; sb = 1; end
            12: begin sa = 1; sb = 2; pcw = 1; end
            13: begin rs = 3; rw = 1; end
            15: ill = 1;
            default: ;
        endcase
        if (!rn) begin pcw = 0; irw = 0; mw = 0; rw = 0; end
        return {st[3:0], pcw, adr, mw, irw, rs, sa, sb, af, imm, rw, ill};
    endfunction

    // Updates the model with the inputs the DUT is about to sample, then crosses the edge.
    task automatic advance();
        int len;
        logic [23:0] p;
        path_of(instr, len, p);
        if (!rst_n) m_pos = 0;
        else if (m_state == 15) m_pos = m_pos;
        else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) m_pos = m_pos;
        else m_pos = (m_pos + 1) % len;
        m_state = rst_n ? int'(p[4*m_pos +: 4]) : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; instr = 32'h00500093;
        advance();
        advance();
        @(negedge clk);
        n_vec++;
        if (got !== exp_out(m_state, instr, zero, mem_ready, rst_n)) begin
            n_err++; $display("FAIL reset_outputs: got %h expected %h", got, exp_out(m_state, instr, zero, mem_ready, rst_n));
        end
        n_vec++;
        if ({state, illegal, PCWrite, IRWrite} !== 7'b0000_000) begin
            n_err++; $display("FAIL reset_state: got st=%0d ill=%b pcw=%b irw=%b expected 0 0 0 0", state, illegal, PCWrite, IRWrite);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_addi();
        int exp_s [5] = '{0, 1, 7, 8, 0};
        do_reset();
        instr = 32'h00500093; mem_ready = 1'b1; zero = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (got !== exp_out(m_state, instr, zero, mem_ready, rst_n) || state !== 4'(exp_s[c])
                || RegWrite !== (c == 3) || PCWrite !== (c == 0 || c == 4) || IRWrite !== (c == 0 || c == 4)) begin
                n_err++; $display("FAIL addi cycle %0d: got %h expected %h (state %0d)", c, got, exp_out(m_state, instr, zero, mem_ready, rst_n), exp_s[c]);
            end
            advance();
        end
    endtask

    task automatic test_lw_stall();
        int exp_s [10] = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
        logic [9:0] rdy = 10'b1100011100;
        do_reset();
        instr = 32'h0000A103;
        for (int c = 0; c < 10; c++) begin
            mem_ready = rdy[c];
            @(negedge clk);
            n_vec++;
            if (got !== exp_out(m_state, instr, zero, mem_ready, rst_n) || state !== 4'(exp_s[c])) begin
                n_err++; $display("FAIL lw_stall cycle %0d: got %h expected %h (state %0d)", c, got, exp_out(m_state, instr, zero, mem_ready, rst_n), exp_s[c]);
            end
            advance();
        end
        @(negedge clk);
        n_vec++;
        if (state !== 4'd0) begin
            n_err++; $display("FAIL lw_latency: got state %0d expected 0", state);
        end
    endtask

    task automatic test_sw_stall();
        logic [4:0] rdy = 5'b10111;
        logic [4:0] mw  = 5'b11000;
        do_reset();
        instr = 32'h0020A023;
        for (int c = 0; c < 5; c++) begin
            mem_ready = rdy[c];
            @(negedge clk);
            n_vec++;
            if (got !== exp_out(m_state, instr, zero, mem_ready, rst_n) || MemWrite !== mw[c]) begin
                n_err++; $display("FAIL sw_stall cycle %0d: got %h expected %h", c, got, exp_out(m_state, instr, zero, mem_ready, rst_n));
            end
            advance();
        end
        @(negedge clk);
        n_vec++;
        if (state !== 4'd0) begin
            n_err++; $display("FAIL sw_end: got state %0d expected 0", state);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [3] = '{32'h00208063, 32'h00208063, 32'h00209063};
        logic z [3]   = '{1'b1, 1'b0, 1'b0};
        logic tk [3]  = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            do_reset();
            instr = ins[k]; zero = z[k]; mem_ready = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                n_vec++;
                if (got !== exp_out(m_state, instr, zero, mem_ready, rst_n)
                    || (c == 2 && (state !== 4'd9 || PCWrite !== tk[k] || ALUfunc !== 3'b001))) begin
                    n_err++; $display("FAIL branch%0d cycle %0d: got %h expected %h", k, c, got, exp_out(m_state, instr, zero, mem_ready, rst_n));
                end
                advance();
            end
        end
    endtask

    task automatic test_jal_jalr();
        int exp_s [9] = '{0, 1, 10, 8, 0, 1, 11, 12, 8};
        do_reset();
        mem_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) instr = 32'h008000EF;
            if (c == 4) instr = 32'h000080E7;
            @(negedge clk);
            n_vec++;
            if (got !== exp_out(m_state, instr, zero, mem_ready, rst_n) || state !== 4'(exp_s[c])
                || (exp_s[c] == 8 && RegWrite !== 1'b1)) begin
                n_err++; $display("FAIL jal_jalr cycle %0d: got %h expected %h (state %0d)", c, got, exp_out(m_state, instr, zero, mem_ready, rst_n), exp_s[c]);
            end
            advance();
        end
    endtask

    task automatic test_trap();
        do_reset();
        instr = 32'h0000007F; mem_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_vec++;
            if (got !== exp_out(m_state, instr, zero, mem_ready, rst_n) || illegal !== (c >= 2)
                || (c >= 2 && {PCWrite, IRWrite, MemWrite, RegWrite, state} !== 8'h0F)) begin
                n_err++; $display("FAIL trap cycle %0d: got %h expected %h", c, got, exp_out(m_state, instr, zero, mem_ready, rst_n));
            end
            advance();
        end
        rst_n = 1'b0;
        advance();
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (state !== 4'd0 || illegal !== 1'b0) begin
            n_err++; $display("FAIL trap_clear: got st=%0d ill=%b expected st=0 ill=0", state, illegal);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [3:0] rdy = 4'b0111;
        do_reset();
        instr = 32'h0020A023;
        for (int c = 0; c < 4; c++) begin
            mem_ready = rdy[c];
            @(negedge clk);
            if (c < 3) advance();
        end
        n_vec++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            n_err++; $display("FAIL midwrite_setup: got st=%0d mw=%b expected st=5 mw=1", state, MemWrite);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (MemWrite !== 1'b0) begin
            n_err++; $display("FAIL midwrite_drop: got mw=%b expected 0", MemWrite);
        end
        advance();
        rst_n = 1'b1;
        n_vec++;
        if (state !== 4'd0) begin
            n_err++; $display("FAIL midwrite_abort: got state %0d expected 0", state);
        end
    endtask

    task automatic test_random();
        logic [6:0] opc [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        logic [2:0] rf3 [5] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010};
        do_reset();
        for (int k = 0; k < 60; k++) begin
            logic [31:0] r = $urandom;
            int cls = $urandom_range(0, 7);
            bit left = 0;
            bit done = 0;
            int stall = 0;
            r[6:0] = opc[cls];
            if (cls == 0 && $urandom_range(0, 1) == 1) begin
                int s = $urandom_range(0, 4);
                r[31:25] = (s == 1) ? 7'b0100000 : 7'b0000000;
                r[14:12] = rf3[s];
            end
            if (cls == 4) r[14:12] = 3'($urandom_range(0, 2));
            instr = r;
            for (int c = 0; c < 40 && !done; c++) begin
                mem_ready = (stall >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
                stall = mem_ready ? 0 : stall + 1;
                zero = 1'($urandom);
                @(negedge clk);
                n_vec++;
                if (got !== exp_out(m_state, instr, zero, mem_ready, rst_n)) begin
                    n_err++; $display("FAIL random instr %h cycle %0d: got %h expected %h", instr, c, got, exp_out(m_state, instr, zero, mem_ready, rst_n));
                end
                advance();
                if (m_pos != 0) left = 1;
                else if (left) done = 1;
            end
            if (!done) begin
                n_vec++; n_err++;
                $display("FAIL random_timeout instr %h: got no return to FETCH expected one within 40 cycles", instr);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_addi();
        test_lw_stall();
        test_sw_stall();
        test_branch();
        test_jal_jalr();
        test_trap();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I-subset datapath: one shared instruction/data memory, IR/OldPC/Data/ALUOut registers, a single ALU.
- Sequences fetch/decode/execute/writeback, drives every mux select and write enable, and stalls on the memory ready handshake.
- Supports R-type (add/sub/and/or/slt), I-type ALU (addi/xori/ori/slti), lw, sw, beq/bne, jal, jalr and lui.

Parameters:
- STATE_W, 4, width of state debug output.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- instr  input  32  IR contents (opcode [6:0], f3 [14:12], f7 [31:25])
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes read/write this cycle
- PCWrite  output  1  PC <= Result
- AdrSrc  output  1  memory address: 0=PC, 1=Result
- MemWrite  output  1  memory write strobe
- IRWrite  output  1  IR <= memory read data and OldPC <= PC
- ResultSrc  output  2  00=ALUOut, 01=Data reg, 10=ALU result, 11=ImmExt
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  output  2  00=RD2, 01=ImmExt, 10=constant 4
- ALUfunc  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 110 xor
- ImmSrc  output  3  000 I, 001 S, 010 J, 011 B, 100 U; decoded from opcode in every state; 000 for unknown opcodes
- RegWrite  output  1  register file write
- illegal  output  1  sticky illegal-opcode flag
- state  output  STATE_W  current state, for debug

Behaviour:
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR1 11, JALR2 12, LUI 13, TRAP 15.
- Outputs are combinational from state, instr, zero and mem_ready (Moore except the ready/zero gating). Registered state only.
- Reset:
  - rst_n low at a rising edge gives state = FETCH and illegal = 0, aborting any instruction in flight.
  - While rst_n is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- Unlisted outputs default to 0 in each state; ALUfunc defaults to add.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUfunc add, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut <= OldPC+imm). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR1
  - 0110111 -> LUI
  - anything else -> TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Go to MEMREAD if opcode is lw, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until the cycle mem_ready=1, then FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00 -> ALUWB. ALUfunc from {f7,f3}:
  - 0000000_000 add
  - 0100000_000 sub
  - 0000000_111 and
  - 0000000_110 or
  - 0000000_010 slt
  - any other -> add
- EXECI: ALUSrcA=10, ALUSrcB=01 -> ALUWB. ALUfunc from f3:
  - 000 add, 100 xor, 110 or, 010 slt
  - any other -> add
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite = (f3=000 & zero) | (f3=001 & ~zero); any other f3 is never taken.
  - Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 -> ALUWB (rd <= OldPC+4).
- JALR1: ALUSrcA=10, ALUSrcB=01, add -> JALR2.
- JALR2: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, add -> ALUWB.
- LUI: ResultSrc=11, RegWrite=1 -> FETCH.
- TRAP: all enables 0, illegal=1; stays in TRAP until reset.
- Latency in cycles, with mem_ready always 1:
  - lw 5, sw 4
  - R-type / I-type ALU 4
  - branch 3
  - jal 4, jalr 5
  - lui 3
  - each memory wait cycle adds 1.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093), mem_ready=1 -> states 0,1,7,8,0; RegWrite=1 only in ALUWB; PCWrite and IRWrite pulse only in FETCH.
- lw (0x0000A103) with mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> IRWrite stays 0 until ready; MEMWB reached after exactly 3 stalled MEMREAD cycles; total 10 cycles.
- sw with mem_ready low 1 cycle in MEMWRITE -> MemWrite=1 for 2 consecutive cycles, then FETCH.
- beq (f3=000) with zero=1, then zero=0; then bne with zero=0 -> PCWrite=1, 0, 1 respectively in BRANCH, ALUfunc=001.
- jal then jalr -> PCWrite in JAL and JALR2 respectively; each ends in ALUWB with RegWrite=1, ALUSrcA=01 and ALUSrcB=10 in the prior state.
- Opcode 0x7F in DECODE -> TRAP, illegal=1 held 10 cycles with no enables; rst_n=0 for 1 cycle -> FETCH, illegal=0. Separately, reset mid-MEMWRITE -> MemWrite drops the same cycle.
